// File: rtl/menu_controlador_pkg.sv
// menu_controlador_pkg: shared FSM state encoding and action codes for the pet menu.
package menu_controlador_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BROWSE = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    typedef enum logic [1:0] {
        ACT_FEED  = 2'd0,
        ACT_PLAY  = 2'd1,
        ACT_SLEEP = 2'd2,
        ACT_CLEAN = 2'd3
    } action_e;
endpackage

// File: rtl/menu_timeout.sv
// menu_timeout: counts ticks without a press; expired pulses on the tick that reaches the limit.
module menu_timeout #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int TO_W          = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    // A press in the same cycle as a tick wins, so clear masks the expiry.
    assign expired = enable & tick & ~clear & (cnt == TO_W'(TIMEOUT_TICKS - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= (clear | ~enable | expired) ? '0 : tick ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/menu_controlador.sv
// menu_controlador: turns debounced button pulses into a wrapping menu cursor and a
// single valid/ready action command, closing the menu after an inactivity timeout.
module menu_controlador
    import menu_controlador_pkg::*;
#(
    parameter int N_OPT         = 4,
    parameter int SEL_W         = 2,
    parameter int TIMEOUT_TICKS = 10,
    parameter int TO_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b_prev,
    input  logic             b_next,
    input  logic             b_ok,
    input  logic             b_back,
    input  logic             tick,
    output logic             menu_active,
    output logic [SEL_W-1:0] menu_sel,
    output logic             action_valid,
    output logic [SEL_W-1:0] action_code,
    input  logic             action_ready
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OPT - 1);
    logic [1:0]       state;
    logic             press;
    logic             expired;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] sel_dec;
    assign press   = b_back | b_ok | b_next | b_prev;
    assign sel_inc = (menu_sel == LAST) ? '0 : menu_sel + 1'b1;
    assign sel_dec = (menu_sel == '0) ? LAST : menu_sel - 1'b1;
    menu_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .TO_W         (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (press),
        .tick   (tick),
        .enable (state == S_BROWSE),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            menu_active  <= 1'b0;
            menu_sel     <= '0;
            action_valid <= 1'b0;
            action_code  <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (b_ok | b_next | b_prev) begin
                        state       <= S_BROWSE;
                        menu_active <= 1'b1;
                        menu_sel    <= '0;
                    end
                S_BROWSE:
                    if (b_back | (expired & ~press)) begin
                        state       <= S_IDLE;
                        menu_active <= 1'b0;
                    end else if (b_ok) begin
                        state        <= S_ISSUE;
                        action_valid <= 1'b1;
                        action_code  <= menu_sel;
                    end else if (b_next)
                        menu_sel <= sel_inc;
                    else if (b_prev)
                        menu_sel <= sel_dec;
                // Once issued, the action can only leave through the handshake.
                S_ISSUE:
                    if (action_ready) begin
                        state        <= S_IDLE;
                        menu_active  <= 1'b0;
                        action_valid <= 1'b0;
                    end
                default: begin
                    state        <= S_IDLE;
                    menu_active  <= 1'b0;
                    menu_sel     <= '0;
                    action_valid <= 1'b0;
                    action_code  <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/menu_controlador.md
Name: menu_controlador

Overview:
- Consumes the one-cycle press pulses produced by the per-button debouncers.
- Turns them into menu navigation plus a single action command for the pet-state core.
- Runs a wrapping selection cursor, a confirm/back flow and an inactivity timeout.
- Delivers the chosen action over a valid/ready handshake.

Parameters:
- N_OPT, 4, number of menu options; legal range 2..2**SEL_W.
- SEL_W, 2, width of the selection index and the action code.
- TIMEOUT_TICKS, 10, number of tick pulses without a press before the menu closes; must be ≥1.
- TO_W, 4, width of the timeout counter; must satisfy TIMEOUT_TICKS < 2**TO_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- b_prev  in  1  one-cycle pulse: move cursor back.
- b_next  in  1  one-cycle pulse: move cursor forward.
- b_ok  in  1  one-cycle pulse: wake menu / confirm.
- b_back  in  1  one-cycle pulse: close menu.
- tick  in  1  one-cycle timebase pulse (e.g. 1 Hz strobe).
- menu_active  out  1  high while the menu is open (BROWSE or ISSUE).
- menu_sel  out  SEL_W  current cursor position.
- action_valid  out  1  action command valid.
- action_code  out  SEL_W  selected action, stable while action_valid=1.
- action_ready  in  1  consumer accepts the action.

Behaviour:
- All outputs are registered. While rst=1, asynchronously: state=IDLE, menu_sel=0, action_valid=0, action_code=0, menu_active=0, timeout count=0.
- Inputs are sampled at each rising edge; a sampled pulse takes effect in that same edge's update, so it is visible one edge after the pulse is asserted.
- Simultaneous presses are resolved by priority: b_back > b_ok > b_next > b_prev. Only the winner acts; the others are dropped.
- IDLE:
  - b_ok, b_next or b_prev → BROWSE, menu_sel=0, menu_active=1, timeout=0. The waking press does not move the cursor.
  - b_back and tick are ignored.
- BROWSE:
  - b_next: menu_sel = (menu_sel==N_OPT-1) ? 0 : menu_sel+1.
  - b_prev: menu_sel = (menu_sel==0) ? N_OPT-1 : menu_sel-1.
  - b_ok → ISSUE: action_code=menu_sel, action_valid=1 at the same edge.
  - b_back → IDLE, menu_active=0; menu_sel holds its value.
  - Timeout:
    - Any press clears the counter.
    - Otherwise a tick increments it.
    - If a tick would bring the count to TIMEOUT_TICKS → IDLE, menu_active=0, counter=0.
    - If a press and a tick occur in the same cycle, the press wins: counter cleared, no increment.
- ISSUE:
  - action_valid is held at 1 and action_code is held stable until the first edge where action_ready=1.
  - At that edge: action_valid=0 → IDLE, menu_active=0.
  - Exactly one transfer occurs per confirm.
  - All button pulses and ticks are ignored in ISSUE; the action cannot be cancelled and valid never drops without ready.
  - action_ready is ignored in every other state.
- rst asserted mid-ISSUE drops action_valid immediately, with no transfer counted.
- State encoding: IDLE=0, BROWSE=1, ISSUE=2. Any unreachable encoding recovers to IDLE on the next edge with all outputs at their reset values.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - action code constants: ACT_FEED=0, ACT_PLAY=1, ACT_SLEEP=2, ACT_CLEAN=3.
- One natural sub-module: menu_timeout.
  - Inputs: clk, rst, clear, tick, enable.
  - Output: expired (one-cycle).
  - Parameterised by TIMEOUT_TICKS and TO_W.

Test Plan:
- Wake and wrap: reset; b_ok → menu_active=1, menu_sel=0. Then b_next ×4 → sel 1,2,3,0. Then b_prev → sel 3.
- Confirm handshake: in BROWSE at sel=2, b_ok with action_ready=0 for 5 cycles → action_valid=1, action_code=2 held for all 5. Raise ready → valid=0 and menu_active=0 after that edge, with exactly one transfer.
- Ignore during ISSUE: while valid=1, pulse b_next, b_back and tick → action_code stays 2 and state stays ISSUE.
- Priority: in BROWSE, assert b_back and b_ok in the same cycle → IDLE with no action_valid. Assert b_next and b_prev together → sel+1.
- Timeout: TIMEOUT_TICKS=3, 2 ticks then b_next then 2 ticks → still open. Third consecutive tick → menu_active=0. A press coinciding with a tick → counter reset.
- Async reset: assert rst mid-ISSUE between clock edges → action_valid=0 and menu_sel=0 without waiting for a clock edge. After release, an idle tick has no effect.
